// File: rtl/sprite_anim_rom.sv
// sprite_anim_rom: multi-frame packed sprite pixel ROM with an on-chip animation sequencer.
// Latency: q is 2 cycles after address; size_x/size_y follow cur_frame by 1 cycle.
// Backpressure: none; fully pipelined, a new address is accepted every cycle with no stall.
//
// Ports:
//   clock, reset_n      system clock, asynchronous active-low reset
//   frame_tick          one-cycle pulse per video field; the only time a running sequence advances
//   anim_start          (re)start the sequence from anim_mode/anim_first/anim_last/anim_rate
//   anim_mode           0 LOOP, 1 PINGPONG, 2 ONESHOT, 3 MANUAL
//   anim_rate           frame_ticks per frame step (0 behaves as 1); anim_hold freezes dwell counting
//   frame_sel           frame shown in MANUAL mode, sampled at frame_tick
//   address             sprite-relative pixel index (row*size_x+col)
//   q                   palette index, TRANSPARENT outside the frame or outside the pixel memory
//   cur_frame, size_x, size_y, anim_done   sequencer/descriptor status
module sprite_anim_rom #(
  parameter int    NUM_FRAMES  = 9,
  parameter int    FRAME_W     = 5,
  parameter int    ADDR_W      = 14,
  parameter int    MEM_DEPTH   = 90000,
  parameter int    MEM_AW      = 17,
  parameter int    PIX_W       = 4,
  parameter int    SIZE_W      = 7,
  parameter int    RATE_W      = 4,
  parameter int    TRANSPARENT = 0,
  parameter string PIX_INIT    = "sprite.mif",
  parameter string DESC_INIT   = "sprite_desc.mif",
  // 1: pixel/descriptor contents held in ROM arrays.
  // 0: use the built-in reference sprite (procedural pixels, fixed descriptor table).
  parameter bit    INIT_FILES  = 1'b1
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                frame_tick,
  input  logic                anim_start,
  input  logic [1:0]          anim_mode,
  input  logic [FRAME_W-1:0]  anim_first,
  input  logic [FRAME_W-1:0]  anim_last,
  input  logic [RATE_W-1:0]   anim_rate,
  input  logic                anim_hold,
  input  logic [FRAME_W-1:0]  frame_sel,
  input  logic [ADDR_W-1:0]   address,
  output logic [PIX_W-1:0]    q,
  output logic [FRAME_W-1:0]  cur_frame,
  output logic [SIZE_W-1:0]   size_x,
  output logic [SIZE_W-1:0]   size_y,
  output logic                anim_done
);

  localparam int DESC_W = MEM_AW + 2 * SIZE_W;
  localparam int AREA_W = 2 * SIZE_W;
  localparam int CHUNKS = (MEM_AW + PIX_W - 1) / PIX_W;

  localparam logic [1:0] MODE_LOOP     = 2'd0;
  localparam logic [1:0] MODE_PINGPONG = 2'd1;
  localparam logic [1:0] MODE_ONESHOT  = 2'd2;
  localparam logic [1:0] MODE_MANUAL   = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_MANUAL} state_e;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  function automatic logic [FRAME_W-1:0] clamp_first(input logic [FRAME_W-1:0] f);
    return (int'(f) >= NUM_FRAMES) ? '0 : f;
  endfunction

  function automatic logic [FRAME_W-1:0] clamp_last(input logic [FRAME_W-1:0] l);
    return (int'(l) >= NUM_FRAMES) ? FRAME_W'(NUM_FRAMES - 1) : l;
  endfunction

  // Built-in reference sprite: six 110x86 frames, one 110x96 frame and two
  // 105x108 frames packed back to back, filling 90000 words exactly.
  function automatic logic [DESC_W-1:0] default_desc(input logic [FRAME_W-1:0] f);
    int fi, base, sx, sy;
    fi = int'(f);
    if (fi < 6) begin
      base = 9460 * fi; sx = 110; sy = 86;
    end else if (fi == 6) begin
      base = 56760; sx = 110; sy = 96;
    end else if (fi < 9) begin
      base = 67320 + 11340 * (fi - 7); sx = 105; sy = 108;
    end else begin
      base = 0; sx = 0; sy = 0;
    end
    return {MEM_AW'(base), SIZE_W'(sx), SIZE_W'(sy)};
  endfunction

  // Built-in pixel content: XOR-fold of the word address into one palette index.
  function automatic logic [PIX_W-1:0] pattern_pix(input logic [MEM_AW-1:0] a);
    logic [CHUNKS*PIX_W-1:0] ext;
    logic [PIX_W-1:0]        r;
    ext = (CHUNKS*PIX_W)'(a);
    r   = '0;
    for (int i = 0; i < CHUNKS; i++) r = r ^ ext[i*PIX_W +: PIX_W];
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Animation sequencer
  // ---------------------------------------------------------------------------
  state_e              state_q, state_d;
  logic [1:0]          mode_q, mode_d;
  logic [FRAME_W-1:0]  first_q, first_d;
  logic [FRAME_W-1:0]  last_q, last_d;
  logic [RATE_W-1:0]   rate_q, rate_d;
  logic                dir_q, dir_d;      // 0 forward, 1 reverse (PINGPONG only)
  logic [RATE_W-1:0]   dwell_q, dwell_d;
  logic [FRAME_W-1:0]  cur_q, cur_d;
  logic                done_q, done_d;

  logic [FRAME_W-1:0]  start_first, start_last_c, start_last;
  logic [RATE_W-1:0]   rate_m1;

  assign start_first  = clamp_first(anim_first);
  assign start_last_c = clamp_last(anim_last);
  // An inverted range collapses to the single frame 'first'.
  assign start_last   = (start_first > start_last_c) ? start_first : start_last_c;
  assign rate_m1      = (rate_q == '0) ? '0 : rate_q - RATE_W'(1);

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    first_d = first_q;
    last_d  = last_q;
    rate_d  = rate_q;
    dir_d   = dir_q;
    dwell_d = dwell_q;
    cur_d   = cur_q;
    done_d  = done_q;

    // A start in the same cycle as a tick swallows that tick.
    if (anim_start) begin
      mode_d  = anim_mode;
      first_d = start_first;
      last_d  = start_last;
      rate_d  = anim_rate;
      cur_d   = start_first;
      dir_d   = 1'b0;
      dwell_d = '0;
      done_d  = 1'b0;
      state_d = (anim_mode == MODE_MANUAL) ? S_MANUAL : S_RUN;
    end else if (frame_tick) begin
      case (state_q)
        S_RUN: begin
          if (!anim_hold) begin
            if (dwell_q == rate_m1) begin
              dwell_d = '0;
              case (mode_q)
                MODE_LOOP: cur_d = (cur_q == last_q) ? first_q : cur_q + FRAME_W'(1);
                MODE_PINGPONG: begin
                  if (first_q != last_q) begin
                    if (!dir_q) begin
                      if (cur_q == last_q) begin
                        dir_d = 1'b1;
                        cur_d = cur_q - FRAME_W'(1);
                      end else begin
                        cur_d = cur_q + FRAME_W'(1);
                      end
                    end else begin
                      if (cur_q == first_q) begin
                        dir_d = 1'b0;
                        cur_d = cur_q + FRAME_W'(1);
                      end else begin
                        cur_d = cur_q - FRAME_W'(1);
                      end
                    end
                  end
                end
                MODE_ONESHOT: begin
                  if (cur_q == last_q) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                  end else begin
                    cur_d = cur_q + FRAME_W'(1);
                  end
                end
                default: ;
              endcase
            end else begin
              dwell_d = dwell_q + RATE_W'(1);
            end
          end
        end
        S_MANUAL: cur_d = clamp_first(frame_sel);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      mode_q  <= MODE_LOOP;
      first_q <= '0;
      last_q  <= '0;
      rate_q  <= '0;
      dir_q   <= 1'b0;
      dwell_q <= '0;
      cur_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      first_q <= first_d;
      last_q  <= last_d;
      rate_q  <= rate_d;
      dir_q   <= dir_d;
      dwell_q <= dwell_d;
      cur_q   <= cur_d;
      done_q  <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Descriptor lookup (registered) and pixel memory read
  // ---------------------------------------------------------------------------
  logic [DESC_W-1:0]  desc_rd;
  logic [MEM_AW-1:0]  base_q;
  logic [SIZE_W-1:0]  size_x_q, size_y_q;
  logic [MEM_AW-1:0]  mem_addr_q;
  logic               oob_q;
  logic [PIX_W-1:0]   rd_pix;
  logic [PIX_W-1:0]   q_q;

  if (INIT_FILES) begin : g_file
    logic [DESC_W-1:0] desc_mem [2**FRAME_W];
    logic [PIX_W-1:0]  pix_mem  [MEM_DEPTH];
    initial begin
      for (int i = 0; i < 2**FRAME_W; i++) desc_mem[i] = default_desc(FRAME_W'(i));
      for (int i = 0; i < MEM_DEPTH; i++)  pix_mem[i]  = pattern_pix(MEM_AW'(i));
    end
    assign desc_rd = desc_mem[cur_q];
    assign rd_pix  = (int'(mem_addr_q) < MEM_DEPTH) ? pix_mem[mem_addr_q] : PIX_W'(TRANSPARENT);
  end else begin : g_builtin
    assign desc_rd = default_desc(cur_q);
    assign rd_pix  = pattern_pix(mem_addr_q);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      base_q   <= '0;
      size_x_q <= '0;
      size_y_q <= '0;
    end else begin
      base_q   <= desc_rd[DESC_W-1 -: MEM_AW];
      size_x_q <= desc_rd[2*SIZE_W-1 -: SIZE_W];
      size_y_q <= desc_rd[SIZE_W-1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Pixel pipeline: stage 1 address/bounds, stage 2 memory read
  // ---------------------------------------------------------------------------
  logic [AREA_W-1:0] area;
  assign area = AREA_W'(size_x_q) * AREA_W'(size_y_q);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_addr_q <= '0;
      oob_q      <= 1'b1;   // keeps q transparent until real data flows
      q_q        <= PIX_W'(TRANSPARENT);
    end else begin
      mem_addr_q <= base_q + MEM_AW'(address);
      oob_q      <= (int'(address) >= int'(area));
      // Addresses past the end of the packed memory never read stale words.
      q_q        <= (oob_q || (int'(mem_addr_q) >= MEM_DEPTH)) ? PIX_W'(TRANSPARENT) : rd_pix;
    end
  end

  assign q         = q_q;
  assign cur_frame = cur_q;
  assign size_x    = size_x_q;
  assign size_y    = size_y_q;
  assign anim_done = done_q;

endmodule

// File: tb/tb_sprite_anim_rom.sv
module tb_sprite_anim_rom;

  localparam int NF = 9;
  localparam int FW = 5;
  localparam int AW = 14;
  localparam int MD = 90000;
  localparam int PW = 4;
  localparam int SW = 7;
  localparam int RW = 4;
  localparam int TR = 0;

  logic           clock = 1'b0;
  logic           reset_n = 1'b1;
  logic           frame_tick = 1'b0;
  logic           anim_start = 1'b0;
  logic [1:0]     anim_mode = '0;
  logic [FW-1:0]  anim_first = '0;
  logic [FW-1:0]  anim_last = '0;
  logic [RW-1:0]  anim_rate = '0;
  logic           anim_hold = 1'b0;
  logic [FW-1:0]  frame_sel = '0;
  logic [AW-1:0]  address = '0;
  logic [PW-1:0]  q;
  logic [FW-1:0]  cur_frame;
  logic [SW-1:0]  size_x, size_y;
  logic           anim_done;

  sprite_anim_rom #(.INIT_FILES(1'b0)) dut (
    .clock(clock), .reset_n(reset_n), .frame_tick(frame_tick), .anim_start(anim_start),
    .anim_mode(anim_mode), .anim_first(anim_first), .anim_last(anim_last),
    .anim_rate(anim_rate), .anim_hold(anim_hold), .frame_sel(frame_sel),
    .address(address), .q(q), .cur_frame(cur_frame), .size_x(size_x),
    .size_y(size_y), .anim_done(anim_done)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference sprite content
  int t_base [NF] = '{0, 9460, 18920, 28380, 37840, 47300, 56760, 67320, 78660};
  int t_sx   [NF] = '{110, 110, 110, 110, 110, 110, 110, 105, 105};
  int t_sy   [NF] = '{86, 86, 86, 86, 86, 86, 96, 108, 108};

  function automatic int pat(int a);
    return (a % 16) ^ ((a / 16) % 16) ^ ((a / 256) % 16) ^ ((a / 4096) % 16) ^ ((a / 65536) % 16);
  endfunction

  function automatic int calc(int addr, int df);
    int ma;
    if (df < 0) return TR;
    if (addr >= t_sx[df] * t_sy[df]) return TR;
    ma = (t_base[df] + addr) % 131072;
    if (ma >= MD) return TR;
    return pat(ma);
  endfunction

  function automatic int clampf(int f);
    return (f >= NF) ? 0 : f;
  endfunction

  // Behavioural model: the running frame is derived from the number of
  // counted ticks since start, not from an incremental state machine.
  int m_mode, m_first, m_last, m_rate, m_ticks, m_frame, desc_f, p_s1;
  bit m_run, m_man, m_done;
  int g_sel = 0;
  int g_addr = 0;

  task automatic model_reset();
    m_run = 0; m_man = 0; m_done = 0; m_frame = 0; m_ticks = 0;
    m_mode = 0; m_first = 0; m_last = 0; m_rate = 1;
    desc_f = -1; p_s1 = TR;
  endtask

  // Drive one cycle at a negedge, let the posedge pass, then check at the next negedge.
  task automatic cyc(input bit tick, input bit start, input bit hold, input int mode,
                     input int first, input int last, input int rate, input int sel, input int addr);
    int exp_q, n, s, p, cf, cl;
    frame_tick = tick; anim_start = start; anim_hold = hold;
    anim_mode = 2'(mode); anim_first = FW'(first); anim_last = FW'(last);
    anim_rate = RW'(rate); frame_sel = FW'(sel); address = AW'(addr);
    @(negedge clock);
    exp_q = p_s1;
    p_s1 = calc(addr, desc_f);
    desc_f = m_frame;
    if (start) begin
      cf = clampf(first);
      cl = (last >= NF) ? NF - 1 : last;
      if (cf > cl) cl = cf;
      m_mode = mode; m_first = cf; m_last = cl; m_rate = (rate == 0) ? 1 : rate;
      m_ticks = 0; m_frame = cf; m_done = 0;
      m_man = (mode == 3); m_run = (mode != 3);
    end else if (tick && m_man) begin
      m_frame = clampf(sel);
    end else if (tick && m_run && !hold && !m_done) begin
      m_ticks++;
      n = m_last - m_first + 1;
      s = m_ticks / m_rate;
      case (m_mode)
        0: m_frame = m_first + s % n;
        1: begin
          if (n == 1) m_frame = m_first;
          else begin
            p = s % (2 * (n - 1));
            m_frame = (p < n) ? m_first + p : m_last - (p - (n - 1));
          end
        end
        default: begin
          m_frame = (s >= n - 1) ? m_last : m_first + s;
          if (s >= n) m_done = 1;
        end
      endcase
    end
    check("cur_frame", cur_frame, m_frame);
    check("anim_done", anim_done, m_done);
    check("size_x", size_x, (desc_f < 0) ? 0 : t_sx[desc_f]);
    check("size_y", size_y, (desc_f < 0) ? 0 : t_sy[desc_f]);
    check("q", q, exp_q);
  endtask

  task automatic tk(input bit hold);
    cyc(1'b1, 1'b0, hold, 0, 0, 0, 0, g_sel, g_addr);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b0, 0, 0, 0, 0, g_sel, g_addr);
  endtask

  task automatic st(input int mode, input int first, input int last, input int rate, input bit tick);
    cyc(tick, 1'b1, 1'b0, mode, first, last, rate, g_sel, g_addr);
  endtask

  // Asynchronous reset away from any clock edge; outputs must clear at once.
  task automatic do_reset();
    frame_tick = 1'b0; anim_start = 1'b0; anim_hold = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("rst_cur_frame", cur_frame, 0);
    check("rst_q", q, TR);
    check("rst_size_x", size_x, 0);
    check("rst_size_y", size_y, 0);
    check("rst_anim_done", anim_done, 0);
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  int exp1 [10] = '{0, 1, 1, 2, 2, 3, 3, 0, 0, 1};
  int exp2 [7]  = '{3, 4, 3, 2, 3, 4, 3};

  initial begin
    model_reset();
    @(negedge clock);
    do_reset();
    idle(2);

    // LOOP 0..3, two ticks per frame
    st(0, 0, 3, 2, 1'b0);
    check("t1_start", cur_frame, 0);
    for (int i = 0; i < 10; i++) begin
      tk(1'b0);
      check("t1_loop", cur_frame, exp1[i]);
      idle(1);
    end

    // PINGPONG 2..4
    st(1, 2, 4, 1, 1'b0);
    for (int i = 0; i < 7; i++) begin
      tk(1'b0);
      check("t2_pingpong", cur_frame, exp2[i]);
    end

    // ONESHOT 6..8, then restart clears done
    st(2, 6, 8, 1, 1'b0);
    tk(1'b0); check("t3_f1", cur_frame, 7); check("t3_d1", anim_done, 0);
    tk(1'b0); check("t3_f2", cur_frame, 8); check("t3_d2", anim_done, 0);
    tk(1'b0); check("t3_f3", cur_frame, 8); check("t3_d3", anim_done, 1);
    tk(1'b0); check("t3_f4", cur_frame, 8); check("t3_d4", anim_done, 1);
    st(0, 0, 1, 1, 1'b0);
    check("t3_restart_done", anim_done, 0);

    // Frame 6 descriptor and pixel latency/bounds
    st(3, 6, 6, 1, 1'b0);
    idle(1);
    check("t4_size_x", size_x, 110);
    check("t4_size_y", size_y, 96);
    cyc(1'b0, 1'b0, 1'b0, 0, 0, 0, 0, g_sel, 0);
    cyc(1'b0, 1'b0, 1'b0, 0, 0, 0, 0, g_sel, 10560);
    check("t4_q_addr0", q, pat(56760));
    cyc(1'b0, 1'b0, 1'b0, 0, 0, 0, 0, g_sel, 10559);
    check("t4_q_oob", q, TR);
    idle(1);
    check("t4_q_last", q, pat(56760 + 10559));

    // Hold, and start coincident with tick
    st(0, 1, 3, 1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tk(1'b1);
      check("t5_hold", cur_frame, 1);
    end
    tk(1'b0);
    check("t5_release", cur_frame, 2);
    st(0, 1, 3, 2, 1'b1);
    check("t5_start_tick", cur_frame, 1);
    tk(1'b0);
    check("t5_dwell_reset", cur_frame, 1);
    tk(1'b0);
    check("t5_step", cur_frame, 2);

    // MANUAL with clamping, then reset mid-run
    st(3, 0, 8, 1, 1'b0);
    g_sel = 12;
    tk(1'b0);
    check("t6_clamp", cur_frame, 0);
    g_sel = 5;
    idle(2);
    check("t6_between", cur_frame, 0);
    tk(1'b0);
    check("t6_sel5", cur_frame, 5);
    st(0, 0, 8, 1, 1'b0);
    tk(1'b0); tk(1'b0); tk(1'b0);
    check("t6_running", cur_frame, 3);
    do_reset();
    tk(1'b0);
    check("t6_idle_after_reset", cur_frame, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 299);
      g_addr = $urandom_range(0, 12000);
      g_sel = $urandom_range(0, 15);
      if (r < 2) do_reset();
      else if (r < 17)
        cyc($urandom_range(0, 1) == 1, 1'b1, 1'b0, $urandom_range(0, 3), $urandom_range(0, 15),
            $urandom_range(0, 15), $urandom_range(0, 3), g_sel, g_addr);
      else
        cyc($urandom_range(0, 2) == 0, 1'b0, $urandom_range(0, 4) == 0, 0, 0, 0, 0, g_sel, g_addr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
